alu_execute_unit: RTL and testbench
===================================

Name: alu_execute_unit

Overview:
- EX-stage ALU. It sits directly downstream of the ALU control decoder and consumes its 4-bit aluControlInput code plus the register operands.
- Logic ops and add/sub/slt/sltu complete in one cycle. Shifts run iteratively, one bit position per cycle, so no barrel shifter is needed.
- Results are held in an output register behind a valid/ready handshake, so the pipeline can stall EX cleanly.

Parameters:
- WIDTH, 32, datapath width of operands and result
- SHAMT_W, 5, width of the shift-amount field (log2 WIDTH)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- inValid  in  1  operation request valid
- inReady  out  1  unit can accept an operation this cycle
- aluControlInput  in  4  operation code from ALU control
- operandA  in  WIDTH  rs value
- operandB  in  WIDTH  rt value or sign-extended immediate
- shamt  in  SHAMT_W  shift amount for sll/srl
- outValid  out  1  result registers valid
- outReady  in  1  downstream consumes result
- aluResult  out  WIDTH  registered result
- zero  out  1  aluResult == 0
- overflow  out  1  signed overflow on add/sub
- illegalOp  out  1  unsupported code was accepted
- busy  out  1  state != IDLE

Behaviour:
- Op codes:
  - 0010 add: A+B
  - 0110 sub: A-B
  - 0000 and
  - 0001 or
  - 0011 sll: B<<shamt
  - 0100 srl: B>>shamt, logical, zero fill
  - 0111 slt: signed A<B gives 1, else 0
  - 1011 sltu: unsigned A<B
  - Any other code: result 0, illegalOp=1.
- Reset (rst_n=0 at a clk edge): state=IDLE; aluResult=0, zero=0, overflow=0, illegalOp=0, outValid=0, shift counter=0.
  - Reset has priority over every other event. Asserting it mid-shift or in DONE aborts the operation and drops the result.
- FSM states are IDLE, SHIFT, DONE. inReady = (state==IDLE) and is combinational. Accept = inValid & inReady.
- IDLE:
  - On accept of a non-shift op: compute the result and load the output registers; go to DONE. outValid rises the next cycle, so latency is 1.
  - On accept of a shift with shamt==0: load aluResult=B; go to DONE.
  - On accept of a shift with shamt>0: latch B into the shift register, counter=shamt, and latch the direction; go to SHIFT.
- SHIFT:
  - Each cycle: shift 1 bit in the latched direction and decrement the counter.
  - When the counter is 1 at the clock edge, write the final shifted value to aluResult and go to DONE.
  - Total latency is shamt+1 cycles from accept to outValid.
  - Input changes during SHIFT are ignored.
- DONE:
  - outValid=1. aluResult, zero, overflow and illegalOp stay stable until the handshake completes.
  - On outReady=1: go to IDLE and clear outValid the next cycle.
  - No new accept in the same cycle as the result handoff, so peak throughput is 1 op per 2 cycles.
- Arithmetic:
  - add/sub are WIDTH-bit modulo.
  - overflow is set when both operands (B inverted for sub) have the same sign and the result sign differs. It is 0 for all non-add/sub ops.
  - zero is computed from the final registered result, including shifts and illegal ops (illegal gives zero=1).
- Shifts with shamt=WIDTH-1 are legal (31 cycles of shifting). The counter never wraps, because the SHIFT exit happens at count 1.
- illegalOp is updated only on accept and is cleared on the next accept of a legal op.
- busy=1 in SHIFT and DONE.

Test Plan:
- Reset then idle: after rst_n low for 2 cycles → outValid=0, aluResult=0, inReady=1, busy=0.
- add overflow: A=0x7FFFFFFF, B=0x00000001, code 0010, outReady=1 → 1 cycle later aluResult=0x80000000, overflow=1, zero=0; sub A=5,B=5 → aluResult=0, zero=1, overflow=0.
- slt vs sltu: A=0xFFFFFFFF, B=0x00000001 → slt gives 1, sltu gives 0.
- Iterative shift: sll B=0x00000003 shamt=4 → inReady low 5 cycles, outValid after 5 cycles, aluResult=0x00000030. srl B=0x80000000 shamt=31 → 0x00000001 after 32 cycles. shamt=0 → result=B after 1 cycle.
- Backpressure: result ready with outReady=0 for 3 cycles → aluResult/outValid stable, inReady=0, new inValid ignored. outReady=1 → outValid drops next cycle, inReady=1.
- Illegal code 1111 → aluResult=0, zero=1, illegalOp=1. A following add 2+3 → 5 and illegalOp=0. rst_n low mid-shift (cycle 3 of shamt=10) → IDLE next cycle, outValid never asserted.

Source files
------------

// File: rtl/alu_execute_unit.sv
// ---------------------------------------------------------------------------
// alu_execute_unit
//
// EX-stage ALU. It sits behind the ALU control decoder. Logic operations and
// add/sub/slt/sltu finish in one cycle. Shifts move one bit position per
// cycle through a shift register, so the design needs no barrel shifter.
// The result is held in an output register until the consumer takes it.
//
// Handshake: an operation is accepted on a rising edge where
// inValid & inReady. inReady is high only while the unit is IDLE. A result is
// handed off on a rising edge where outValid & outReady. Every result output
// holds its value while outValid is high and outReady is low.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   inValid/inReady  operation request handshake
//   aluControlInput  4-bit operation code
//   operandA/B       operands (B is also the shift source)
//   shamt            shift amount for sll/srl
//   outValid/Ready   result handshake
//   aluResult        registered result
//   zero             aluResult == 0
//   overflow         signed overflow of add/sub
//   illegalOp        last accepted code was unsupported
//   busy             unit is in SHIFT or DONE
//   dbg_state_o      current FSM state (IDLE=0, SHIFT=1, DONE=2)
// ---------------------------------------------------------------------------
module alu_execute_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inValid,
  output logic               inReady,
  input  logic [3:0]         aluControlInput,
  input  logic [WIDTH-1:0]   operandA,
  input  logic [WIDTH-1:0]   operandB,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               outValid,
  input  logic               outReady,
  output logic [WIDTH-1:0]   aluResult,
  output logic               zero,
  output logic               overflow,
  output logic               illegalOp,
  output logic               busy,
  output logic [1:0]         dbg_state_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    result_q;
  logic                zero_q;
  logic                ovf_q;
  logic                illegal_q;
  logic                out_valid_q;
  logic [WIDTH-1:0]    shreg_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic                dir_left_q;

  // Single-cycle result computed directly from the input operands
  logic [WIDTH-1:0]    sum;
  logic [WIDTH-1:0]    diff;
  logic [WIDTH-1:0]    calc_res;
  logic                calc_ovf;
  logic                calc_ill;
  logic                is_shift;
  logic                shift_left;
  logic [WIDTH-1:0]    shift_next;

  always_comb begin
    sum        = operandA + operandB;
    diff       = operandA - operandB;
    calc_res   = '0;
    calc_ovf   = 1'b0;
    calc_ill   = 1'b0;
    is_shift   = 1'b0;
    shift_left = 1'b0;
    case (aluControlInput)
      OP_ADD: begin
        calc_res = sum;
        calc_ovf = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                   (sum[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_SUB: begin
        // Overflow rule applied to A + ~B: the operand signs differ
        calc_res = diff;
        calc_ovf = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                   (diff[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_AND:  calc_res = operandA & operandB;
      OP_OR:   calc_res = operandA | operandB;
      OP_SLT:  calc_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
      OP_SLTU: calc_res = {{(WIDTH-1){1'b0}}, (operandA < operandB)};
      OP_SLL: begin
        is_shift   = 1'b1;
        shift_left = 1'b1;
        calc_res   = operandB;   // final value when shamt == 0
      end
      OP_SRL: begin
        is_shift = 1'b1;
        calc_res = operandB;
      end
      default: calc_ill = 1'b1;
    endcase
  end

  assign shift_next = dir_left_q ? (shreg_q << 1) : (shreg_q >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dir_left_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inValid) begin
            illegal_q <= calc_ill;
            ovf_q     <= calc_ovf;
            if (is_shift && (shamt != '0)) begin
              shreg_q    <= operandB;
              cnt_q      <= shamt;
              dir_left_q <= shift_left;
              state_q    <= SHIFT;
            end else begin
              result_q    <= calc_res;
              zero_q      <= (calc_res == '0);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        SHIFT: begin
          // Exit at count 1 so the counter never wraps below zero
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q    <= shift_next;
            zero_q      <= (shift_next == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            shreg_q <= shift_next;
          end
        end
        DONE: begin
          if (outReady) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inReady     = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign outValid    = out_valid_q;
  assign aluResult   = result_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign illegalOp   = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_execute_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_execute_unit
//
// Transaction-level model of the ALU: each accepted operation is evaluated
// with plain arithmetic and published after its latency (1 cycle, or
// shamt+1 cycles for a non-zero shift). A negedge compare process checks
// every output against the model on every cycle. Directed cases pin the
// model with literal values, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_alu_execute_unit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        inValid = 1'b0;
  logic        inReady;
  logic [3:0]  aluControlInput = 4'b0;
  logic [W-1:0] operandA = '0;
  logic [W-1:0] operandB = '0;
  logic [4:0]  shamt = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [W-1:0] aluResult;
  logic        zero;
  logic        overflow;
  logic        illegalOp;
  logic        busy;
  logic [1:0]  dbg_state;

  alu_execute_unit #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inValid         (inValid),
    .inReady         (inReady),
    .aluControlInput (aluControlInput),
    .operandA        (operandA),
    .operandB        (operandB),
    .shamt           (shamt),
    .outValid        (outValid),
    .outReady        (outReady),
    .aluResult       (aluResult),
    .zero            (zero),
    .overflow        (overflow),
    .illegalOp       (illegalOp),
    .busy            (busy),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%0h expected=%0h state=%0d t=%0t", name, got, exp, dbg_state, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] exp_res   = '0;
  logic         exp_zero  = 1'b0;
  logic         exp_ovf   = 1'b0;
  logic         exp_ill   = 1'b0;
  logic         exp_valid = 1'b0;
  logic         exp_ready = 1'b1;
  int           wait_cnt  = 0;      // cycles left before a shift result shows
  logic [W-1:0] pend_res  = '0;
  logic [W-1:0] exp_q[$];           // results still to be handed off

  task automatic compute(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] s, output logic [W-1:0] r, output logic ov,
                         output logic il, output logic sh);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; ov = 1'b0; il = 1'b0; sh = 1'b0;
    case (c)
      4'b0010: begin r = a + b; ov = ((sa + sb) > 64'sh7FFFFFFF) || ((sa + sb) < -64'sh80000000); end
      4'b0110: begin r = a - b; ov = ((sa - sb) > 64'sh7FFFFFFF) || ((sa - sb) < -64'sh80000000); end
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: begin r = b << s; sh = 1'b1; end
      4'b0100: begin r = b >> s; sh = 1'b1; end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1011: r = (a < b) ? 32'd1 : 32'd0;
      default: il = 1'b1;
    endcase
  endtask

  // Called once per rising edge with the inputs seen at that edge
  task automatic model_update();
    logic [W-1:0] r;
    logic ov, il, sh;
    if (!rst_n) begin
      exp_res = '0; exp_zero = 1'b0; exp_ovf = 1'b0; exp_ill = 1'b0;
      exp_valid = 1'b0; exp_ready = 1'b1; wait_cnt = 0;
      exp_q.delete();
    end else if (exp_ready && inValid) begin
      compute(aluControlInput, operandA, operandB, shamt, r, ov, il, sh);
      exp_ill = il;
      exp_ovf = ov;
      exp_ready = 1'b0;
      if (sh && shamt != 0) begin
        wait_cnt = shamt;
        pend_res = r;
      end else begin
        exp_res = r; exp_zero = (r == 0); exp_valid = 1'b1;
        exp_q.push_back(r);
      end
    end else if (wait_cnt != 0) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        exp_res = pend_res; exp_zero = (pend_res == 0); exp_valid = 1'b1;
        exp_q.push_back(pend_res);
      end
    end else if (exp_valid && outReady) begin
      void'(exp_q.pop_front());
      exp_valid = 1'b0;
      exp_ready = 1'b1;
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("inReady",   W'(inReady),   W'(exp_ready));
        chk("busy",      W'(busy),      W'(!exp_ready));
        chk("outValid",  W'(outValid),  W'(exp_valid));
        chk("aluResult", aluResult,     exp_res);
        chk("zero",      W'(zero),      W'(exp_zero));
        chk("overflow",  W'(overflow),  W'(exp_ovf));
        chk("illegalOp", W'(illegalOp), W'(exp_ill));
        if (exp_valid && exp_q.size() > 0) chk("head_result", aluResult, exp_q[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] s);
    bit acc;
    acc = 1'b0;
    inValid = 1'b1; aluControlInput = c; operandA = a; operandB = b; shamt = s;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = inReady;
      tick();
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    inValid = 1'b0;
    aluControlInput = 4'($urandom); operandA = $urandom; operandB = $urandom;
    shamt = 5'($urandom);
  endtask

  // Returns cycles from accept to outValid (accept cycle counts as 1)
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] s, output int lat);
    issue(c, a, b, s);
    lat = 1;
    while (!outValid && lat < 100) begin
      tick();
      lat++;
    end
    if (!outValid) chk("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic handoff();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("handoff_outValid", W'(outValid), 32'd0);
    chk("handoff_inReady",  W'(inReady),  32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int seen;
    logic [W-1:0] held;

    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rst_outValid",  W'(outValid), 32'd0);
    chk("rst_aluResult", aluResult,    32'd0);
    chk("rst_inReady",   W'(inReady),  32'd1);
    chk("rst_busy",      W'(busy),     32'd0);

    // add overflow, then sub to zero
    run_op(4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0, lat);
    chk("add_lat", lat, 32'd1);
    chk("add_res", aluResult, 32'h80000000);
    chk("add_ovf", W'(overflow), 32'd1);
    chk("add_zero", W'(zero), 32'd0);
    handoff();
    run_op(4'b0110, 32'd5, 32'd5, 5'd0, lat);
    chk("sub_res", aluResult, 32'd0);
    chk("sub_zero", W'(zero), 32'd1);
    chk("sub_ovf", W'(overflow), 32'd0);
    handoff();

    // slt vs sltu
    run_op(4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0, lat);
    chk("slt_res", aluResult, 32'd1);
    handoff();
    run_op(4'b1011, 32'hFFFFFFFF, 32'h00000001, 5'd0, lat);
    chk("sltu_res", aluResult, 32'd0);
    handoff();

    // iterative shifts
    run_op(4'b0011, 32'h0, 32'h00000003, 5'd4, lat);
    chk("sll_lat", lat, 32'd5);
    chk("sll_res", aluResult, 32'h00000030);
    handoff();
    run_op(4'b0100, 32'h0, 32'h80000000, 5'd31, lat);
    chk("srl31_lat", lat, 32'd32);
    chk("srl31_res", aluResult, 32'h00000001);
    handoff();
    run_op(4'b0011, 32'h0, 32'h0000ABCD, 5'd0, lat);
    chk("sh0_lat", lat, 32'd1);
    chk("sh0_res", aluResult, 32'h0000ABCD);

    // backpressure: result held, new request ignored
    held = aluResult;
    inValid = 1'b1; aluControlInput = 4'b0010; operandA = 32'd1; operandB = 32'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", W'(outValid), 32'd1);
      chk("bp_hold", aluResult, held);
      chk("bp_inReady", W'(inReady), 32'd0);
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    inValid = 1'b0;
    chk("bp_drop_valid", W'(outValid), 32'd0);
    chk("bp_inReady_back", W'(inReady), 32'd1);

    // illegal code, then a legal add clears illegalOp
    run_op(4'b1111, 32'h1234, 32'h5678, 5'd0, lat);
    chk("ill_res", aluResult, 32'd0);
    chk("ill_zero", W'(zero), 32'd1);
    chk("ill_flag", W'(illegalOp), 32'd1);
    handoff();
    run_op(4'b0010, 32'd2, 32'd3, 5'd0, lat);
    chk("add_after_ill_res", aluResult, 32'd5);
    chk("add_after_ill_flag", W'(illegalOp), 32'd0);
    handoff();

    // reset in the middle of a shift aborts it
    issue(4'b0011, 32'h0, 32'h00000001, 5'd10);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", W'(busy), 32'd0);
    chk("abort_inReady", W'(inReady), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (outValid) seen++;
    end
    chk("abort_no_valid", seen, 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      inValid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0: aluControlInput = 4'b0010;
        1: aluControlInput = 4'b0110;
        2: aluControlInput = 4'b0000;
        3: aluControlInput = 4'b0001;
        4: aluControlInput = 4'b0011;
        5: aluControlInput = 4'b0100;
        6: aluControlInput = 4'b0111;
        7: aluControlInput = 4'b1011;
        default: aluControlInput = 4'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: operandA = 32'h7FFFFFFF;
        1: operandA = 32'h80000000;
        default: operandA = $urandom;
      endcase
      operandB = ($urandom_range(0, 4) == 0) ? operandA : $urandom;
      shamt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      outReady = ($urandom_range(0, 9) < 6);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    inValid = 1'b0;
    outReady = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
